// File: rtl/video_math_pkg.sv
// Shared types and constants for the video math arbiter and its arithmetic units.
package video_math_pkg;

  localparam int unsigned A_W = 24;  // divide numerator / result width
  localparam int unsigned B_W = 12;  // divide denominator / multiply operand 2 width
  localparam int unsigned M_W = 12;  // multiply operand 1 width (low bits of arg_a)

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam logic [A_W-1:0] DIV0_RES_DEFAULT = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN
  } state_e;

  // Index width for n requesters; never zero so NREQ=1 still gets a 1-bit pointer.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import video_math_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]          req,
  input  logic [idx_w(NREQ)-1:0]   ptr,
  output logic                     valid_c,
  output logic [idx_w(NREQ)-1:0]   idx_c
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = IW + 1;

  logic [CW-1:0] cand;

  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    cand    = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!valid_c && req[cand[IW-1:0]]) begin
        valid_c = 1'b1;
        idx_c   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/sys_udiv.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle; run is high for NW cycles.
module sys_udiv #(
  parameter int unsigned NW = 24,
  parameter int unsigned DW = 12
) (
  input  logic          clk,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          run,
  output logic [NW-1:0] quo
);

  localparam int unsigned CW = $clog2(NW + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] den_q, den_d;
  logic [NW-1:0] quo_q, quo_d;
  logic          run_q, run_d;
  logic [DW:0]   shifted;

  // No reset: a stale count simply drains to zero, so run always falls eventually.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    rem_q <= rem_d;
    den_q <= den_d;
    quo_q <= quo_d;
    run_q <= run_d;
  end

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    den_d   = den_q;
    quo_d   = quo_q;
    shifted = {rem_q, quo_q[NW-1]};
    if (start) begin
      cnt_d = CW'(NW);
      rem_d = '0;
      den_d = den;
      quo_d = num;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (shifted >= {1'b0, den_q}) begin
        rem_d = DW'(shifted - {1'b0, den_q});
        quo_d = {quo_q[NW-2:0], 1'b1};
      end else begin
        rem_d = shifted[DW-1:0];
        quo_d = {quo_q[NW-2:0], 1'b0};
      end
    end
    run_d = (cnt_d != '0);
  end

  assign run = run_q;
  assign quo = quo_q;

endmodule

// File: rtl/sys_umul.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle; run is high for BW cycles.
module sys_umul #(
  parameter int unsigned AW = 12,
  parameter int unsigned BW = 12
) (
  input  logic             clk,
  input  logic             start,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic             run,
  output logic [AW+BW-1:0] prod
);

  localparam int unsigned PW = AW + BW;
  localparam int unsigned CW = $clog2(BW + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [BW-1:0] mplier_q, mplier_d;
  logic          run_q, run_d;

  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    run_q    <= run_d;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      cnt_d    = CW'(BW);
      acc_d    = '0;
      mcand_d  = PW'(a);
      mplier_d = b;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - 1'b1;
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = {mcand_q[PW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[BW-1:1]};
    end
    run_d = (cnt_d != '0);
  end

  assign run  = run_q;
  assign prod = acc_q;

endmodule

// File: rtl/video_math_arbiter.sv
// Round-robin sharing of one divider and one multiplier among NREQ video requesters.
module video_math_arbiter
  import video_math_pkg::*;
#(
  parameter int unsigned    NREQ     = 2,
  parameter logic [A_W-1:0] DIV0_RES = DIV0_RES_DEFAULT
) (
  input  logic                  CLK_VIDEO,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op,
  input  logic [A_W*NREQ-1:0]   arg_a,
  input  logic [B_W*NREQ-1:0]   arg_b,
  output logic [NREQ-1:0]       done,
  output logic [A_W-1:0]        res,
  output logic                  busy
);

  localparam int unsigned IW = idx_w(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            opsel_q, opsel_d;
  logic [A_W-1:0]  a_q, a_d;
  logic [B_W-1:0]  b_q, b_d;
  logic            armed_q, armed_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [A_W-1:0]  res_q, res_d;
  logic            busy_q, busy_d;
  logic            div_start_q, div_start_d;
  logic            mul_start_q, mul_start_d;

  logic [A_W-1:0]  a_slot [NREQ];
  logic [B_W-1:0]  b_slot [NREQ];
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            div_run, mul_run, sel_run;
  logic [A_W-1:0]  div_quo;
  logic [A_W-1:0]  mul_prod;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign a_slot[g] = arg_a[A_W*g +: A_W];
    assign b_slot[g] = arg_b[B_W*g +: B_W];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  // Units are not reset: an operation cut off by reset runs out and is discarded.
  sys_udiv #(.NW(A_W), .DW(B_W)) u_div (
    .clk   (CLK_VIDEO),
    .start (div_start_q),
    .num   (a_q),
    .den   (b_q),
    .run   (div_run),
    .quo   (div_quo)
  );

  sys_umul #(.AW(M_W), .BW(B_W)) u_mul (
    .clk   (CLK_VIDEO),
    .start (mul_start_q),
    .a     (a_q[M_W-1:0]),
    .b     (b_q),
    .run   (mul_run),
    .prod  (mul_prod)
  );

  assign sel_run = (opsel_q == OP_MUL) ? mul_run : div_run;

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      opsel_q     <= OP_DIV;
      a_q         <= '0;
      b_q         <= '0;
      armed_q     <= 1'b0;
      done_q      <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      opsel_q     <= opsel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      div_start_q <= div_start_d;
      mul_start_q <= mul_start_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    opsel_d     = opsel_q;
    a_d         = a_q;
    b_d         = b_q;
    armed_d     = armed_q;
    done_d      = '0;
    res_d       = res_q;
    div_start_d = 1'b0;
    mul_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Start is registered here so it is high during ISSUE with the latched operands.
        if (!div_run && !mul_run && pick_valid) begin
          idx_d   = pick_idx;
          opsel_d = op[pick_idx];
          a_d     = a_slot[pick_idx];
          b_d     = b_slot[pick_idx];
          ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : IW'(pick_idx + 1'b1);
          if (op[pick_idx] == OP_MUL) begin
            mul_start_d = 1'b1;
          end else if (b_slot[pick_idx] != '0) begin
            div_start_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (opsel_q == OP_DIV && b_q == '0) begin
          res_d         = DIV0_RES;
          done_d[idx_q] = 1'b1;
          state_d       = FIN;
        end else begin
          armed_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        armed_d = 1'b1;
        if (armed_q && !sel_run) begin
          res_d         = (opsel_q == OP_MUL) ? A_W'(mul_prod) : div_quo;
          done_d[idx_q] = 1'b1;
          state_d       = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign done = done_q;
  assign res  = res_q;
  assign busy = busy_q;

endmodule
